mips_boot_mem: RTL
==================

# mips_boot_mem

Memory-side responder for the `mips_cpu_top` instruction and data ports, with a boot loader in front of it. After reset it holds the CPU in reset and accepts a streamed image: instruction words first, then data words. It then releases the CPU and serves instruction fetches and data loads/stores. This block replaces ad-hoc behavioural memories with a synthesizable, loadable memory subsystem.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: word-address bits; each memory holds 2^ADDR_WIDTH words (DEPTH).
- `DATA_WIDTH`, default 32: word width; must equal the CPU datapath width.

Ports:
- `clock`, in, 1: single clock. All state changes on its rising edge.
- `reset`, in, 1: synchronous, active-low.
- `load_valid`, in, 1: a loader beat is present.
- `load_ready`, out, 1: the block can accept a beat.
- `load_data`, in, DATA_WIDTH: loader word.
- `load_last`, in, 1: this beat ends the current segment (instruction or data).
- `cpu_reset`, out, 1: active-high reset to the CPU.
- `boot_done`, out, 1: the image is loaded and the CPU is running.
- `PC`, in, 32: CPU fetch byte address.
- `Inst`, out, DATA_WIDTH: fetched instruction.
- `MemRead`, in, 1: data read enable.
- `MemWrite`, in, 1: data write enable.
- `Addr`, in, 32: data byte address.
- `Din`, in, DATA_WIDTH: store data from the CPU.
- `Dout`, out, DATA_WIDTH: load data to the CPU.
- `addr_err`, out, 1: sticky flag for a misaligned or out-of-range access.

## Operation
- FSM states: LOAD_I, LOAD_D, RUN. Reset (reset==0 at an edge) forces LOAD_I, load counter `cnt`=0, `addr_err`=0.
- Memory arrays are not cleared by reset.
- `load_ready` = (state != RUN) && reset. A beat is accepted when `load_valid && load_ready`.
- LOAD_I: an accepted beat writes InstMem[cnt] and increments `cnt`. The FSM moves to LOAD_D with `cnt`=0 when the beat has `load_last`=1 or `cnt`==DEPTH-1.
- LOAD_D: same rule, writing DataMem. The terminating beat moves the FSM to RUN.
- RUN: loader beats are ignored; `load_ready`=0. The only exit is reset.
- Beats with `load_valid` low are not counted. Gaps of any length are legal.
- `cpu_reset`=1 and `boot_done`=0 in LOAD_I and LOAD_D; `cpu_reset`=0 and `boot_done`=1 in RUN. Both are registered from state.
- Fetch:
  - In RUN, `Inst` = InstMem[PC>>2] (combinational read).
  - `Inst`=0 (NOP) when not in RUN, when PC[1:0]!=0, or when PC>>2 >= DEPTH.
  - A bad PC in RUN sets `addr_err`.
- Data read: in RUN with MemRead=1, `Dout` = DataMem[Addr>>2] (combinational). Otherwise `Dout`=0.
- Data write: in RUN with MemWrite=1, DataMem[Addr>>2] <= Din at the edge.
- A data access with Addr[1:0]!=0 or Addr>>2 >= DEPTH:
  - write dropped;
  - `Dout`=0;
  - `addr_err` set at the next edge.
- `addr_err` stays set until reset.
- MemRead and MemWrite to the same address in one cycle: `Dout` shows the old word (read-before-write). The new word is visible from the next cycle.
- MemWrite while not in RUN: ignored.

## Timing
- Reset values of outputs: `load_ready`=0 while reset is low, 1 afterwards; `cpu_reset`=1; `boot_done`=0; `addr_err`=0; `Inst`=0; `Dout`=0.
- Load throughput: one word per cycle.
- On the edge accepting the last data beat, the state becomes RUN. In the same cycle `cpu_reset` falls, `boot_done` rises and `load_ready` falls.
- Fetch and load latency: 0 cycles (combinational from PC/Addr). Store: committed at the edge where MemWrite is sampled.
- Reset asserted mid-load or mid-run: at the next edge the state is LOAD_I, `cnt`=0, `cpu_reset`=1. A partial image may remain in the arrays and is overwritten by the new load.

## Structure
- Package `mips_mem_pkg` holds:
  - the state enum (LOAD_I, LOAD_D, RUN);
  - `NOP_WORD`=32'h0;
  - default ADDR_WIDTH/DATA_WIDTH constants;
  - the address-range check function.
- Sub-module `mips_word_ram`, instantiated twice (instruction and data): one synchronous write port and one asynchronous read port, parameterized by ADDR_WIDTH/DATA_WIDTH.
- The top holds the FSM, counter, address checks and output muxing.

## Test plan
- **Basic boot:** reset low 2 cycles. Load instructions 20030007, 00602024, 00032880 (last on the 3rd), then data 8, 9 (last on the 2nd).
  - During load: `cpu_reset`=1.
  - At the final beat's edge: `cpu_reset`→0, `boot_done`→1.
  - PC=4 → `Inst`=00602024.
- **Data path:** MemRead with Addr=4 → `Dout`=9. MemWrite Addr=8, Din=7, then MemRead Addr=8 → 7. Same-cycle read+write at Addr=0 with Din=5 → `Dout`=8 that cycle, 5 next.
- **Backpressure and gaps:** `load_valid` toggling 1,0,0,1 → only valid beats are stored and counted, with correct InstMem indices.
- **Overflow:** 256 instruction beats without `load_last` → auto-advance to LOAD_D after beat 256; the next beat lands in DataMem[0].
- **Errors:** in RUN, MemRead Addr=6 → `Dout`=0 and `addr_err`=1 next cycle. MemWrite Addr=32'h400 → no array change. PC=2 → `Inst`=0. `addr_err` holds until reset.
- **Reset mid-load:** reset after 1 data beat → LOAD_I, `cpu_reset`=1, `boot_done`=0. Reloading works; beats in RUN are ignored (`load_ready`=0).

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types, constants and the word-address range check for the MIPS boot memory.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      StLoadI,
      StLoadD,
      StRun
   } state_e;

   localparam logic [31:0] NOP_WORD = 32'h0;

   localparam int unsigned DEFAULT_ADDR_WIDTH = 8;
   localparam int unsigned DEFAULT_DATA_WIDTH = 32;

   // True when a byte address is word aligned and its word index fits in 2^aw words.
   function automatic logic addr_ok(input logic [31:0] addr, input int unsigned aw);
      logic [31:0] word;
      word = addr >> 2;
      return (addr[1:0] == 2'b00) && ((word >> aw) == 32'd0);
   endfunction

endpackage

// File: rtl/mips_word_ram.sv
// Word-wide RAM: one synchronous write port, one asynchronous read port, no reset.
module mips_word_ram
   import mips_mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mips_boot_mem.sv
// Boot loader plus instruction/data memories: streams an image in, then serves the CPU ports.
module mips_boot_mem
   import mips_mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_last,
   output logic                  cpu_reset,
   output logic                  boot_done,
   input  logic [31:0]           PC,
   output logic [DATA_WIDTH-1:0] Inst,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [31:0]           Addr,
   input  logic [DATA_WIDTH-1:0] Din,
   output logic [DATA_WIDTH-1:0] Dout,
   output logic                  addr_err
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  addr_err_q, addr_err_d;
   logic                  cpu_reset_q, boot_done_q;

   logic                  run, accept, seg_end, pc_ok, d_ok;
   logic [ADDR_WIDTH-1:0] pc_idx, d_idx;

   logic                  imem_we, dmem_we;
   logic [ADDR_WIDTH-1:0] dmem_waddr;
   logic [DATA_WIDTH-1:0] dmem_wdata, imem_rdata, dmem_rdata;

   assign run        = (state_q == StRun);
   assign load_ready = !run && reset;
   assign accept     = load_valid && load_ready;
   // A segment also closes on its last slot so the counter never wraps into live words.
   assign seg_end    = load_last || (cnt_q == {ADDR_WIDTH{1'b1}});

   assign pc_ok  = addr_ok(PC, ADDR_WIDTH);
   assign d_ok   = addr_ok(Addr, ADDR_WIDTH);
   assign pc_idx = PC[ADDR_WIDTH+1:2];
   assign d_idx  = Addr[ADDR_WIDTH+1:2];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_err_d = addr_err_q;
      unique case (state_q)
         StLoadI: begin
            if (accept) begin
               if (seg_end) begin
                  state_d = StLoadD;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + ADDR_WIDTH'(1);
               end
            end
         end
         StLoadD: begin
            if (accept) begin
               if (seg_end) begin
                  state_d = StRun;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + ADDR_WIDTH'(1);
               end
            end
         end
         StRun: begin
            if (!pc_ok || ((MemRead || MemWrite) && !d_ok)) begin
               addr_err_d = 1'b1;
            end
         end
         default: state_d = StLoadI;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= StLoadI;
         cnt_q       <= '0;
         addr_err_q  <= 1'b0;
         cpu_reset_q <= 1'b1;
         boot_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_err_q  <= addr_err_d;
         // Registered from next state so both flip on the edge that enters RUN.
         cpu_reset_q <= (state_d != StRun);
         boot_done_q <= (state_d == StRun);
      end
   end

   assign imem_we    = accept && (state_q == StLoadI);
   assign dmem_we    = (accept && (state_q == StLoadD)) || (run && reset && MemWrite && d_ok);
   assign dmem_waddr = run ? d_idx : cnt_q;
   assign dmem_wdata = run ? Din : load_data;

   mips_word_ram #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) u_imem (
      .clk_i  (clock),
      .we_i   (imem_we),
      .waddr_i(cnt_q),
      .wdata_i(load_data),
      .raddr_i(pc_idx),
      .rdata_o(imem_rdata)
   );

   mips_word_ram #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) u_dmem (
      .clk_i  (clock),
      .we_i   (dmem_we),
      .waddr_i(dmem_waddr),
      .wdata_i(dmem_wdata),
      .raddr_i(d_idx),
      .rdata_o(dmem_rdata)
   );

   assign Inst      = (run && pc_ok) ? imem_rdata : DATA_WIDTH'(NOP_WORD);
   assign Dout      = (run && MemRead && d_ok) ? dmem_rdata : DATA_WIDTH'(NOP_WORD);
   assign cpu_reset = cpu_reset_q;
   assign boot_done = boot_done_q;
   assign addr_err  = addr_err_q;

endmodule
